// File: rtl/tdm_demux8_if.sv
// ============================================================================
// Module   : tdm_demux8_if
// Brief    : Serial-in / parallel-out bundle for the 8-slot TDM demultiplexer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface tdm_demux8_if #(
    parameter int N_CH  = 8,
    parameter int SEL_W = 3
);
    logic              din;
    logic              din_valid;
    logic              sof;
    logic [N_CH-1:0]   Y;
    logic              Y_valid;
    logic [SEL_W-1:0]  slot;
    logic              frame_abort;
    logic              parity_err;

    // Serial source side
    modport master (
        output din, din_valid, sof,
        input  Y, Y_valid, slot, frame_abort, parity_err
    );

    // Demultiplexer side
    modport slave (
        input  din, din_valid, sof,
        output Y, Y_valid, slot, frame_abort, parity_err
    );
endinterface

`default_nettype wire

// File: rtl/tdm_demux8.sv
// ============================================================================
// Module   : tdm_demux8
// Brief    : 1-to-8 time-division demultiplexer; LSB-first serial beats are
//            gathered into a shadow word and published as a parallel frame.
//            Optional trailing even-parity beat: TDM_DEMUX_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tdm_demux8 #(
    parameter int N_CH  = 8,
    parameter int SEL_W = 3
) (
    input  wire logic        clk,
    input  wire logic        rst,
    tdm_demux8_if.slave      bus
);

    localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(N_CH - 1);
    localparam logic [SEL_W-1:0] ONE_SLOT  = SEL_W'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_COLLECT = 2'b01,
        S_PARITY  = 2'b10
    } state_t;

    state_t            state_q;
    logic [N_CH-1:0]   shadow_q;
    logic [N_CH-1:0]   shadow_d;
    logic [N_CH-1:0]   y_q;
    logic              y_valid_q;
    logic [SEL_W-1:0]  slot_q;
    logic              abort_q;

    // Shadow word with the incoming bit dropped into the current slot
    always_comb begin
        shadow_d         = shadow_q;
        shadow_d[slot_q] = bus.din;
    end

`ifdef TDM_DEMUX_PARITY_EN
    logic parity_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            shadow_q  <= '0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
            slot_q    <= '0;
            abort_q   <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            y_valid_q <= 1'b0;
            abort_q   <= 1'b0;
            if (bus.din_valid) begin
                case (state_q)
                    S_IDLE: begin
                        if (bus.sof) begin
                            shadow_q[0] <= bus.din;
                            slot_q      <= ONE_SLOT;
                            state_q     <= S_COLLECT;
                        end
                    end
                    S_COLLECT: begin
                        // sof wins even on the final slot: abort and restart
                        if (bus.sof) begin
                            abort_q     <= 1'b1;
                            shadow_q[0] <= bus.din;
                            slot_q      <= ONE_SLOT;
                        end else if (slot_q == LAST_SLOT) begin
                            shadow_q  <= shadow_d;
`ifdef TDM_DEMUX_PARITY_EN
                            state_q   <= S_PARITY;
`else
                            y_q       <= {bus.din, shadow_q[N_CH-2:0]};
                            y_valid_q <= 1'b1;
                            slot_q    <= '0;
                            state_q   <= S_IDLE;
`endif
                        end else begin
                            shadow_q <= shadow_d;
                            slot_q   <= slot_q + ONE_SLOT;
                        end
                    end
`ifdef TDM_DEMUX_PARITY_EN
                    S_PARITY: begin
                        if (bus.sof) begin
                            abort_q     <= 1'b1;
                            shadow_q[0] <= bus.din;
                            slot_q      <= ONE_SLOT;
                            state_q     <= S_COLLECT;
                        end else begin
                            y_q       <= shadow_q;
                            y_valid_q <= 1'b1;
                            parity_q  <= (^shadow_q) ^ bus.din;
                            slot_q    <= '0;
                            state_q   <= S_IDLE;
                        end
                    end
`endif
                    default: begin
                        state_q <= S_IDLE;
                        slot_q  <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.Y           = y_q;
    assign bus.Y_valid     = y_valid_q;
    assign bus.slot        = slot_q;
    assign bus.frame_abort = abort_q;
`ifdef TDM_DEMUX_PARITY_EN
    assign bus.parity_err  = parity_q;
`else
    assign bus.parity_err  = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_tdm_demux8.sv
// ============================================================================
// Module   : tb_tdm_demux8
// Brief    : Directed self-checking bench for tdm_demux8 (TDM_DEMUX_PARITY_EN aware).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tdm_demux8;

`ifdef TDM_DEMUX_PARITY_EN
    localparam int FRAME_BEATS = 9;
`else
    localparam int FRAME_BEATS = 8;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int vcount = 0;
    int acount = 0;
    int last_v_cyc = 0;
    int prev_v_cyc = 0;

    tdm_demux8_if #(.N_CH(8), .SEL_W(3)) bus ();

    tdm_demux8 #(.N_CH(8), .SEL_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.Y_valid) begin
            vcount     <= vcount + 1;
            prev_v_cyc <= last_v_cyc;
            last_v_cyc <= cyc;
        end
        if (bus.frame_abort) acount <= acount + 1;
    end

    task automatic idle_cycle();
        bus.din_valid = 1'b0;
        bus.sof       = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic d, input logic s);
        bus.din       = d;
        bus.din_valid = 1'b1;
        bus.sof       = s;
        @(posedge clk);
        #1;
        bus.din_valid = 1'b0;
        bus.sof       = 1'b0;
    endtask

    // Bits lo..hi of v, LSB-first, sof on slot 0
    task automatic send_bits(input logic [7:0] v, input int lo, input int hi);
        for (int k = lo; k <= hi; k++) beat(v[k], (k == 0));
    endtask

    task automatic send_parity(input logic [7:0] v);
`ifdef TDM_DEMUX_PARITY_EN
        beat(^v, 1'b0);
`else
        if (v == 8'h00) begin end
`endif
    endtask

    task automatic test_reset();
        bus.din = 1'b0; bus.din_valid = 1'b0; bus.sof = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (bus.Y !== 8'h00) begin bad++; $display("FAIL reset_Y got=%h exp=00", bus.Y); end
        total++; if (bus.Y_valid !== 1'b0) begin bad++; $display("FAIL reset_Yv got=%b exp=0", bus.Y_valid); end
        total++; if (bus.slot !== 3'd0) begin bad++; $display("FAIL reset_slot got=%0d exp=0", bus.slot); end
        total++; if (bus.frame_abort !== 1'b0) begin bad++; $display("FAIL reset_abort got=%b exp=0", bus.frame_abort); end
        total++; if (bus.parity_err !== 1'b0) begin bad++; $display("FAIL reset_par got=%b exp=0", bus.parity_err); end
        rst = 1'b0;
        idle_cycle();
    endtask

    task automatic test_basic();
        int v0;
        // sof=0 beats in IDLE are ignored
        beat(1'b1, 1'b0);
        beat(1'b0, 1'b0);
        total++; if (bus.slot !== 3'd0) begin bad++; $display("FAIL idle_ignore_slot got=%0d exp=0", bus.slot); end
        total++; if (bus.frame_abort !== 1'b0) begin bad++; $display("FAIL idle_ignore_abort got=%b exp=0", bus.frame_abort); end
        v0 = vcount;
        send_bits(8'h4D, 0, 7);
`ifdef TDM_DEMUX_PARITY_EN
        total++; if (bus.slot !== 3'd7) begin bad++; $display("FAIL par_slot got=%0d exp=7", bus.slot); end
        total++; if (bus.Y_valid !== 1'b0) begin bad++; $display("FAIL par_early_Yv got=%b exp=0", bus.Y_valid); end
        beat(1'b0, 1'b0);
        total++; if (bus.parity_err !== 1'b0) begin bad++; $display("FAIL par_good got=%b exp=0", bus.parity_err); end
`endif
        total++; if (bus.Y !== 8'h4D) begin bad++; $display("FAIL basic_Y got=%h exp=4d", bus.Y); end
        total++; if (bus.Y_valid !== 1'b1) begin bad++; $display("FAIL basic_Yv got=%b exp=1", bus.Y_valid); end
        total++; if (bus.slot !== 3'd0) begin bad++; $display("FAIL basic_slot got=%0d exp=0", bus.slot); end
        idle_cycle();
        total++; if (bus.Y_valid !== 1'b0) begin bad++; $display("FAIL basic_Yv_drop got=%b exp=0", bus.Y_valid); end
        total++; if (bus.Y !== 8'h4D) begin bad++; $display("FAIL basic_Y_hold got=%h exp=4d", bus.Y); end
        total++; if (vcount - v0 !== 1) begin bad++; $display("FAIL basic_pulses got=%0d exp=1", vcount - v0); end
    endtask

    task automatic test_gap();
        int v0;
        v0 = vcount;
        send_bits(8'hA5, 0, 3);
        for (int g = 0; g < 3; g++) begin
            idle_cycle();
            total++; if (bus.slot !== 3'd4) begin bad++; $display("FAIL gap_slot got=%0d exp=4", bus.slot); end
        end
        send_bits(8'hA5, 4, 7);
        send_parity(8'hA5);
        total++; if (bus.Y !== 8'hA5) begin bad++; $display("FAIL gap_Y got=%h exp=a5", bus.Y); end
        idle_cycle();
        total++; if (vcount - v0 !== 1) begin bad++; $display("FAIL gap_pulses got=%0d exp=1", vcount - v0); end
    endtask

    task automatic test_abort();
        int v0, a0;
        v0 = vcount; a0 = acount;
        send_bits(8'hFF, 0, 4);
        beat(1'b1, 1'b1);
        total++; if (bus.frame_abort !== 1'b1) begin bad++; $display("FAIL abort_pulse got=%b exp=1", bus.frame_abort); end
        total++; if (bus.slot !== 3'd1) begin bad++; $display("FAIL abort_slot got=%0d exp=1", bus.slot); end
        total++; if (bus.Y !== 8'hA5) begin bad++; $display("FAIL abort_Y_kept got=%h exp=a5", bus.Y); end
        send_bits(8'h0F, 1, 7);
        send_parity(8'h0F);
        total++; if (bus.Y !== 8'h0F) begin bad++; $display("FAIL abort_newY got=%h exp=0f", bus.Y); end
        idle_cycle();
        total++; if (acount - a0 !== 1) begin bad++; $display("FAIL abort_count got=%0d exp=1", acount - a0); end
        total++; if (vcount - v0 !== 1) begin bad++; $display("FAIL abort_vcount got=%0d exp=1", vcount - v0); end
    endtask

    task automatic test_sof_last();
        int v0, a0;
        v0 = vcount; a0 = acount;
        send_bits(8'h55, 0, 6);
        beat(1'b0, 1'b1);
        total++; if (bus.Y_valid !== 1'b0) begin bad++; $display("FAIL soflast_Yv got=%b exp=0", bus.Y_valid); end
        total++; if (bus.frame_abort !== 1'b1) begin bad++; $display("FAIL soflast_abort got=%b exp=1", bus.frame_abort); end
        send_bits(8'h00, 1, 7);
        send_parity(8'h00);
        total++; if (bus.Y !== 8'h00) begin bad++; $display("FAIL soflast_Y got=%h exp=00", bus.Y); end
        idle_cycle();
        total++; if (acount - a0 !== 1) begin bad++; $display("FAIL soflast_acount got=%0d exp=1", acount - a0); end
        total++; if (vcount - v0 !== 1) begin bad++; $display("FAIL soflast_vcount got=%0d exp=1", vcount - v0); end
    endtask

    task automatic test_back_to_back();
        beat(1'b1, 1'b0);
        send_bits(8'h3C, 0, 7);
        send_parity(8'h3C);
        total++; if (bus.Y !== 8'h3C || bus.Y_valid !== 1'b1) begin bad++; $display("FAIL b2b_first got=%h/%b exp=3c/1", bus.Y, bus.Y_valid); end
        send_bits(8'hC3, 0, 7);
        send_parity(8'hC3);
        total++; if (bus.Y !== 8'hC3 || bus.Y_valid !== 1'b1) begin bad++; $display("FAIL b2b_second got=%h/%b exp=c3/1", bus.Y, bus.Y_valid); end
        idle_cycle();
        total++; if (last_v_cyc - prev_v_cyc !== FRAME_BEATS) begin
            bad++; $display("FAIL b2b_spacing got=%0d exp=%0d", last_v_cyc - prev_v_cyc, FRAME_BEATS);
        end
    endtask

    task automatic test_async_reset();
        int v0;
        send_bits(8'h77, 0, 6);
        v0 = vcount;
        rst = 1'b1;
        #1;
        total++; if (bus.Y !== 8'h00) begin bad++; $display("FAIL arst_Y got=%h exp=00", bus.Y); end
        total++; if (bus.slot !== 3'd0) begin bad++; $display("FAIL arst_slot got=%0d exp=0", bus.slot); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_cycle();
        total++; if (vcount !== v0) begin bad++; $display("FAIL arst_noYv got=%0d exp=%0d", vcount, v0); end
        send_bits(8'h11, 0, 7);
        send_parity(8'h11);
        total++; if (bus.Y !== 8'h11 || bus.Y_valid !== 1'b1) begin bad++; $display("FAIL arst_next got=%h/%b exp=11/1", bus.Y, bus.Y_valid); end
        idle_cycle();
    endtask

    task automatic test_parity();
`ifdef TDM_DEMUX_PARITY_EN
        send_bits(8'h4D, 0, 7);
        beat(1'b1, 1'b0);
        total++; if (bus.parity_err !== 1'b1 || bus.Y_valid !== 1'b1) begin
            bad++; $display("FAIL par_bad got=%b/%b exp=1/1", bus.parity_err, bus.Y_valid);
        end
        idle_cycle();
        total++; if (bus.parity_err !== 1'b1) begin bad++; $display("FAIL par_hold got=%b exp=1", bus.parity_err); end
        send_bits(8'h4D, 0, 7);
        beat(1'b1, 1'b1);
        total++; if (bus.frame_abort !== 1'b1 || bus.slot !== 3'd1) begin
            bad++; $display("FAIL par_sof got=%b/%0d exp=1/1", bus.frame_abort, bus.slot);
        end
        send_bits(8'h01, 1, 7);
        beat(1'b1, 1'b0);
`else
        send_bits(8'h01, 0, 7);
`endif
        total++; if (bus.Y !== 8'h01 || bus.parity_err !== 1'b0) begin
            bad++; $display("FAIL par_final got=%h/%b exp=01/0", bus.Y, bus.parity_err);
        end
        idle_cycle();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gap();
        test_abort();
        test_sof_last();
        test_back_to_back();
        test_async_reset();
        test_parity();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/tdm_demux8.md
Name: tdm_demux8

Overview:
- Time-division 1-to-8 demultiplexer: the receiving end of an 8:1 select-by-slot serial link.
- Takes one data bit per valid beat and steers it into channel slot 0..7 using an internal slot counter. A frame-start marker realigns the counter.
- Publishes each completed 8-bit frame as a parallel word with a one-cycle valid strobe.
- Sits downstream of any block that serialises an 8-bit word LSB-first, i.e. slot k carries I[k].

Parameters:
- N_CH, 8, number of channel slots; output word width.
- SEL_W, 3, slot counter width; must satisfy 2**SEL_W == N_CH.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous active-high reset.
- din, input, 1, serial data bit.
- din_valid, input, 1, din is sampled on this clk edge.
- sof, input, 1, start of frame; qualified by din_valid; marks the current bit as slot 0.
- Y, output, N_CH, last complete frame; Y[k] = bit received in slot k.
- Y_valid, output, 1, one-cycle pulse when Y is updated.
- slot, output, SEL_W, slot index the next valid bit will be written to.
- frame_abort, output, 1, one-cycle pulse when a partial frame is discarded.
- parity_err, output, 1, parity result of the frame on Y (see Optional Feature).

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, Y=0, Y_valid=0, slot=0, frame_abort=0, parity_err=0. The shadow register is cleared to 0.
- Beat definition: a beat is a clk edge with din_valid=1. With din_valid=0 nothing changes, except that the pulses return to 0.
- IDLE:
  - Beats with sof=0 are ignored.
  - A beat with sof=1 writes din to shadow[0], sets slot=1, and moves to COLLECT.
- COLLECT, beat with sof=0:
  - din is written to shadow[slot] and slot increments.
  - When slot==N_CH-1, the frame is complete. On that edge Y <= {din, shadow[N_CH-2:0]}, slot wraps to 0, and the block returns to IDLE.
  - Y_valid is high for the following cycle only, so latency from the last beat to Y/Y_valid is 1 clk.
- COLLECT, beat with sof=1:
  - The partial frame is discarded and frame_abort pulses for 1 cycle. Y is unchanged.
  - din is written to shadow[0], slot=1, and the state stays COLLECT.
- sof coincident with the final slot: sof takes priority. The result is abort plus restart, with no Y_valid.
- Back-to-back frames: the next beat after completion may carry sof=1 with no idle gap.
- Gaps in din_valid inside a frame are allowed. State holds for any number of idle cycles.
- Shadow bits not yet written in the current frame keep their stale values but are never published.
- Y holds its value until the next completed frame.
- Reset mid-frame: everything returns to the reset values immediately and asynchronously. A pending Y_valid is suppressed.
- A beat with din_valid=1 and sof=0 in IDLE does not raise frame_abort.

Optional Feature:
- Macro: TDM_DEMUX_PARITY_EN.
- When defined:
  - After slot N_CH-1 the block enters a PARITY state and expects one more beat carrying the even-parity bit.
  - On that beat Y is published, Y_valid pulses, and parity_err <= (^data) ^ din. parity_err is held with Y.
  - sof=1 on the parity beat aborts the frame (frame_abort pulse) and restarts at slot 0.
  - slot reads N_CH-1 while in PARITY.
  - Latency from the parity beat to Y_valid is 1 clk.
- When undefined: no PARITY state exists and parity_err is tied to 0.

Test Plan:
- Reset, then 8 consecutive beats (sof on the first) carrying bits 1,0,1,1,0,0,1,0 for slots 0..7 -> Y=8'h4D one cycle after the 8th beat, Y_valid high for exactly 1 cycle, slot=0.
- Frame 8'hA5 sent with din_valid low for 3 cycles between slots 3 and 4 -> Y=8'hA5 with a single Y_valid pulse. slot reads 4 throughout the gap.
- 5 beats of frame 8'hFF, then sof with a new frame 8'h0F -> frame_abort pulses once, Y=8'h0F after its completion, no Y_valid for the aborted frame.
- Two frames 8'h3C and 8'hC3 back-to-back with no gap -> Y_valid pulses 8 cycles apart with the correct values. Beats with sof=0 before the first sof are ignored.
- rst asserted asynchronously after slot 6 of frame 8'h77 -> Y=0 and slot=0 immediately, with no Y_valid. The next full frame 8'h11 publishes correctly.
- With TDM_DEMUX_PARITY_EN defined: frame 8'h4D plus parity bit 0 -> parity_err=0. The same frame with parity bit 1 -> parity_err=1. Y_valid comes 1 clk after the 9th beat in both cases.
